// File: rtl/alu_issue_pkg.sv
// Shared decode types and constants for the ALU issue slice.
// Pure declarations: no latency, no flow control.
// Decode rules for OP / OP-IMM live in decode() so the top stays a thin pipe.
package alu_issue_pkg;

   localparam int REG_W = 32;
   localparam int NREGS = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef struct packed {
      logic             legal;
      logic             use_rs1;
      logic             use_rs2;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [6:0]       funct7;
      logic [2:0]       funct3;
      logic [REG_W-1:0] imm;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] instr);
      dec_t       d;
      logic [6:0] f7;
      f7       = instr[31:25];
      d.rd     = instr[11:7];
      d.rs1    = instr[19:15];
      d.rs2    = instr[24:20];
      d.funct3 = instr[14:12];
      d.funct7 = F7_BASE;
      d.imm    = {{20{instr[31]}}, instr[31:20]};
      d.legal  = 1'b0;
      d.use_rs2 = 1'b0;
      case (instr[6:0])
         OPC_OP: begin
            d.funct7  = f7;
            d.legal   = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((d.funct3 == F3_ADD) || (d.funct3 == F3_SR)));
            d.use_rs2 = d.legal;
         end
         OPC_OP_IMM: begin
            // Shifts carry shamt in the imm field; everything else forces funct7 so ADDI never becomes SUB.
            case (d.funct3)
               F3_SLL: begin
                  d.imm   = {27'b0, instr[24:20]};
                  d.legal = (f7 == F7_BASE);
               end
               F3_SR: begin
                  d.imm    = {27'b0, instr[24:20]};
                  d.funct7 = f7;
                  d.legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               default: d.legal = 1'b1;
            endcase
         end
         default: d.legal = 1'b0;
      endcase
      d.use_rs1 = d.legal;
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Fetch-side handshake plus the registered operand bus to the combinational ALU.
// No latency of its own; instr_valid/instr_ready carries backpressure.
interface alu_issue_if;
   import alu_issue_pkg::*;

   logic             instr_valid;
   logic             instr_ready;
   logic [31:0]      instr;
   logic [REG_W-1:0] alu_operand1;
   logic [REG_W-1:0] alu_operand2;
   logic [6:0]       alu_funct7;
   logic [2:0]       alu_funct3;
   logic             alu_valid;
   logic [REG_W-1:0] alu_result;
   logic             illegal_instr;

   modport master (
      input  instr_valid, instr, alu_result,
      output instr_ready, alu_operand1, alu_operand2, alu_funct7, alu_funct3,
             alu_valid, illegal_instr
   );

   modport slave (
      output instr_valid, instr, alu_result,
      input  instr_ready, alu_operand1, alu_operand2, alu_funct7, alu_funct3,
             alu_valid, illegal_instr
   );
endinterface

// File: rtl/alu_regfile.sv
// 32x32 register file: two async read ports, one debug read port, one sync write port.
// Reads are combinational; a write lands at the edge and is visible next cycle. No backpressure.
module alu_regfile
   import alu_issue_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rd1_addr,
   output logic [REG_W-1:0] rd1_data,
   input  logic [4:0]       rd2_addr,
   output logic [REG_W-1:0] rd2_data,
   input  logic [4:0]       dbg_addr,
   output logic [REG_W-1:0] dbg_data,
   input  logic             wr_en,
   input  logic [4:0]       wr_addr,
   input  logic [REG_W-1:0] wr_data
);

   logic [REG_W-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en && (wr_addr != 5'd0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // x0 is muxed to zero on read so entry 0 never needs special write handling.
   assign rd1_data = (rd1_addr == 5'd0) ? '0 : regs[rd1_addr];
   assign rd2_data = (rd2_addr == 5'd0) ? '0 : regs[rd2_addr];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Decode -> execute/writeback issue pipe feeding a combinational ALU; optional ALU_ISSUE_FWD_EN forwarding.
// Accept at edge N, operands valid N..N+1, result written at N+1.
// Without forwarding a RAW hazard on the S1 rd drops instr_ready for one cycle.
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int XLEN                  = 32,
   parameter bit RESET_PC_UNUSED_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_if.master      bus,
   input  logic [4:0]       dbg_rd_addr,
   output logic [REG_W-1:0] dbg_rd_data
);

   dec_t            dec;
   logic [XLEN-1:0] rf_rs1, rf_rs2;
   logic [XLEN-1:0] op1_d, src2_d, op2_d;
   logic            haz_rs1, haz_rs2, accept, wr_en;

   logic            s1_vld, s1_ill;
   logic [4:0]      s1_rd;
   logic [XLEN-1:0] s1_op1, s1_op2;
   logic [6:0]      s1_f7;
   logic [2:0]      s1_f3;

   assign dec = decode(bus.instr);

   assign haz_rs1 = dec.use_rs1 && s1_vld && (s1_rd != 5'd0) && (dec.rs1 == s1_rd);
   assign haz_rs2 = dec.use_rs2 && s1_vld && (s1_rd != 5'd0) && (dec.rs2 == s1_rd);

`ifdef ALU_ISSUE_FWD_EN
   assign op1_d           = haz_rs1 ? bus.alu_result : rf_rs1;
   assign src2_d          = haz_rs2 ? bus.alu_result : rf_rs2;
   assign bus.instr_ready = 1'b1;
`else
   // The stall cycle lets the S1 write land so the retried read sees it.
   assign op1_d           = rf_rs1;
   assign src2_d          = rf_rs2;
   assign bus.instr_ready = !(haz_rs1 || haz_rs2);
`endif

   assign op2_d  = dec.use_rs2 ? src2_d : dec.imm;
   assign accept = bus.instr_valid && bus.instr_ready;
   assign wr_en  = s1_vld && (s1_rd != 5'd0);

   alu_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd1_addr (dec.rs1),
      .rd1_data (rf_rs1),
      .rd2_addr (dec.rs2),
      .rd2_data (rf_rs2),
      .dbg_addr (dbg_rd_addr),
      .dbg_data (dbg_rd_data),
      .wr_en    (wr_en),
      .wr_addr  (s1_rd),
      .wr_data  (bus.alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_ill <= 1'b0;
         s1_rd  <= '0;
         s1_op1 <= '0;
         s1_op2 <= '0;
         s1_f7  <= '0;
         s1_f3  <= '0;
      end else begin
         s1_vld <= accept && dec.legal;
         s1_ill <= accept && !dec.legal;
         if (accept) begin
            s1_rd  <= dec.rd;
            s1_op1 <= op1_d;
            s1_op2 <= op2_d;
            s1_f7  <= dec.funct7;
            s1_f3  <= dec.funct3;
         end
      end
   end

   assign bus.alu_valid     = s1_vld;
   assign bus.illegal_instr = s1_ill;
   assign bus.alu_operand1  = s1_op1;
   assign bus.alu_operand2  = s1_op2;
   assign bus.alu_funct7    = s1_f7;
   assign bus.alu_funct3    = s1_f3;

   generate
      if (RESET_PC_UNUSED_CHECK) begin : g_rst_chk
         a_no_valid_in_reset: assert property (@(posedge clk) !rst_n |-> !bus.instr_valid);
      end
   endgenerate

endmodule
